key_debounce: RTL and testbench

Parametrised key debouncer and press-event generator for the keypad path. It takes a key-valid level (`IN_key`) and a WIDTH-bit key code (`IN_value`) from the keypad scanner, and requires both to be stable for DEBOUNCE cycles before reporting a press. Each press produces a single-cycle `OUT_key` pulse with a registered code, and optional auto-repeat adds further pulses while the key is held. It sits between the keypad scanner and the command/serial logic.

---
 rtl/key_pkg.sv | 16 +
 rtl/key_debounce.sv | 134 +++++++++++++
 tb/tb_key_debounce.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the keypad debouncer.
// State encodings and a constant helper for counter sizing.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad debouncer: stable key+code for DEBOUNCE cycles yields one
// OUT_key pulse with a registered code, plus optional auto-repeat.
module key_debounce
    import key_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int DEBOUNCE      = 16,
    parameter bit REPEAT_EN     = 1'b0,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 200
) (
    input  logic             IN_clk,
    input  logic             IN_rst,
    input  logic [WIDTH-1:0] IN_value,
    input  logic             IN_key,
    output logic [WIDTH-1:0] OUT_value,
    output logic             OUT_key,
    output logic             OUT_held
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int RW = $clog2(max(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE - 1);
    localparam logic [RW-1:0] DLY_TOP = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_TOP = RW'(REPEAT_PERIOD - 1);

    logic             key_q;
    logic [WIDTH-1:0] val_q;
    state_t           state, state_n;
    logic [WIDTH-1:0] cand, cand_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [RW-1:0]    rcnt, rcnt_n;
    logic             rfirst, rfirst_n;
    logic [WIDTH-1:0] value_n;
    logic             pulse_n;
    logic [RW-1:0]    rtop;

    assign rtop = rfirst ? DLY_TOP : PER_TOP;

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        cnt_n    = cnt;
        rcnt_n   = rcnt;
        rfirst_n = rfirst;
        value_n  = OUT_value;
        pulse_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_q) begin
                    cand_n  = val_q;
                    cnt_n   = '0;
                    state_n = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (!key_q) begin
                    state_n = IDLE;
                end else if (val_q != cand) begin
                    cand_n = val_q;
                    cnt_n  = '0;
                end else if (cnt == CNT_TOP) begin
                    value_n  = cand;
                    pulse_n  = 1'b1;
                    rcnt_n   = '0;
                    rfirst_n = 1'b1;
                    state_n  = HELD;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!key_q) begin
                    cnt_n   = '0;
                    state_n = REL_DB;
                end else if (val_q != OUT_value) begin
                    cand_n  = val_q;
                    cnt_n   = '0;
                    state_n = PRESS_DB;
                end else if (rcnt == rtop) begin
                    // counter still restarts with repeat off, so it never wraps
                    pulse_n  = REPEAT_EN;
                    rcnt_n   = '0;
                    rfirst_n = 1'b0;
                end else begin
                    rcnt_n = rcnt + 1'b1;
                end
            end
            REL_DB: begin
                if (key_q && (val_q == OUT_value)) begin
                    rcnt_n   = '0;
                    rfirst_n = 1'b1;
                    state_n  = HELD;
                end else if (key_q) begin
                    cand_n  = val_q;
                    cnt_n   = '0;
                    state_n = PRESS_DB;
                end else if (cnt == CNT_TOP) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge IN_clk) begin
        if (IN_rst) begin
            key_q     <= 1'b0;
            val_q     <= '0;
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            rcnt      <= '0;
            rfirst    <= 1'b1;
            OUT_value <= '0;
            OUT_key   <= 1'b0;
            OUT_held  <= 1'b0;
        end else begin
            key_q     <= IN_key;
            val_q     <= IN_value;
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            rcnt      <= rcnt_n;
            rfirst    <= rfirst_n;
            OUT_value <= value_n;
            OUT_key   <= pulse_n;
            OUT_held  <= (state_n == HELD) || (state_n == REL_DB);
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: run-length reference model,
// directed scenarios followed by randomized key/code traffic.
module tb_key_debounce;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam bit REN = 1'b1;

    logic         clk = 1'b0;
    logic         rst;
    logic         key;
    logic [W-1:0] val;
    logic [W-1:0] out_value;
    logic         out_key;
    logic         out_held;

    key_debounce #(
        .WIDTH(W), .DEBOUNCE(D), .REPEAT_EN(REN),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .IN_clk(clk), .IN_rst(rst), .IN_value(val), .IN_key(key),
        .OUT_value(out_value), .OUT_key(out_key), .OUT_held(out_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           tag;
        logic [W-1:0] v;
    } pulse_t;

    pulse_t pq[$];
    bit     hq[$];
    int     tests = 0;
    int     fails = 0;
    int     e = 0;
    int     m = 0;

    // reference state: sampled inputs, held flag, run lengths, hold age
    bit           mk;
    logic [W-1:0] mv;
    bit           held;
    logic [W-1:0] out_v;
    logic [W-1:0] run_v;
    int           run, zrun, age;

    function automatic bit rep_due(input int a);
        return REN && (a >= RD) && (((a - RD) % RP) == 0);
    endfunction

    task automatic model(input bit r, input bit k, input logic [W-1:0] v);
        bit pulse;
        pulse = 1'b0;
        if (r) begin
            mk = 1'b0; mv = '0; held = 1'b0;
            run = 0; zrun = 0; age = 0;
        end else begin
            if (!held) begin
                if (!mk) run = 0;
                else if (run > 0 && mv == run_v) run++;
                else begin run = 1; run_v = mv; end
                if (run == D + 1) begin
                    pulse = 1'b1; out_v = run_v; held = 1'b1;
                    zrun = 0; age = 0; run = 0;
                end
            end else if (zrun == 0) begin
                if (!mk) zrun = 1;
                else if (mv != out_v) begin
                    held = 1'b0; run = 1; run_v = mv;
                end else begin
                    age++;
                    pulse = rep_due(age);
                end
            end else begin
                if (mk && mv == out_v) begin
                    zrun = 0; age = 0;
                end else if (mk) begin
                    held = 1'b0; zrun = 0; run = 1; run_v = mv;
                end else begin
                    zrun++;
                    if (zrun == D + 1) begin
                        held = 1'b0; zrun = 0; run = 0;
                    end
                end
            end
            mk = k; mv = v;
        end
        hq.push_back(held);
        if (pulse) pq.push_back('{e, out_v});
    endtask

    task automatic step(input bit r, input bit k, input logic [W-1:0] v);
        rst = r; key = k; val = v;
        @(posedge clk);
        e++;
        model(r, k, v);
        #1;
    endtask

    task automatic hold(input bit k, input logic [W-1:0] v, input int n);
        repeat (n) step(1'b0, k, v);
    endtask

    initial begin : monitor
        bit     h;
        pulse_t p;
        forever begin
            @(negedge clk);
            m++;
            if (hq.size() > 0) begin
                h = hq.pop_front();
                tests++;
                if (out_held !== h) begin
                    fails++;
                    $display("FAIL held cyc=%0d got=%b exp=%b", m, out_held, h);
                end
            end
            while (pq.size() > 0 && pq[0].tag < m) begin
                tests++;
                fails++;
                $display("FAIL missed_pulse cyc=%0d got=none exp=cyc%0d val=%h",
                         m, pq[0].tag, pq[0].v);
                void'(pq.pop_front());
            end
            if (out_key === 1'b1) begin
                tests++;
                if (pq.size() == 0 || pq[0].tag != m) begin
                    fails++;
                    $display("FAIL spurious_pulse cyc=%0d got=1 exp=0", m);
                end else begin
                    p = pq.pop_front();
                    if (out_value !== p.v) begin
                        fails++;
                        $display("FAIL pulse_value cyc=%0d got=%h exp=%h",
                                 m, out_value, p.v);
                    end
                end
            end else if (out_key !== 1'b0) begin
                tests++;
                fails++;
                $display("FAIL key_x cyc=%0d got=%b exp=0/1", m, out_key);
            end
        end
    end

    initial begin : driver
        bit           r, k;
        logic [W-1:0] v;
        int           n;
        rst = 1'b1; key = 1'b0; val = '0;
        repeat (3) step(1'b1, 1'b0, '0);
        hold(1'b0, 4'h0, 3);
        // clean press and release
        hold(1'b1, 4'h7, 8);
        hold(1'b0, 4'h0, 8);
        // key bounce 1,0,1 then steady
        hold(1'b1, 4'h5, 1);
        hold(1'b0, 4'h5, 1);
        hold(1'b1, 4'h5, 10);
        hold(1'b0, 4'h0, 8);
        // transient code before the real one
        hold(1'b1, 4'h3, 2);
        hold(1'b1, 4'h9, 8);
        hold(1'b0, 4'h0, 8);
        // long hold exercising auto-repeat
        hold(1'b1, 4'hA, 26);
        hold(1'b0, 4'h0, 8);
        // release glitch, then real release
        hold(1'b1, 4'h2, 8);
        hold(1'b0, 4'h2, 2);
        hold(1'b1, 4'h2, 4);
        hold(1'b0, 4'h0, 8);
        // reset during press debounce
        hold(1'b1, 4'h6, 4);
        step(1'b1, 1'b1, 4'h6);
        hold(1'b1, 4'h6, 8);
        hold(1'b0, 4'h0, 8);
        // randomized traffic
        repeat (300) begin
            r = ($urandom_range(0, 39) == 0);
            k = ($urandom_range(0, 2) != 0);
            v = W'($urandom_range(0, 3));
            n = $urandom_range(1, 12);
            if (r) step(1'b1, k, v);
            else hold(k, v, n);
        end
        hold(1'b0, 4'h0, 20);
        @(negedge clk);
        #1;
        tests++;
        if (pq.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending exp=0", pq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
